// File: rtl/or_tree_pattern_checker.sv
// or_tree_pattern_checker
// Sweeps every NUM_IN-bit input pattern into a circuit under test and checks
// its two outputs against O0 = OR(all inputs), O1 = NOR(low NOR_WIDTH inputs).
// Reports pass/fail, a saturating mismatch count and the first failing pattern.
//
// Optional feature: define OR_TREE_CHECKER_MISR_EN to compress the responses
// into a 16-bit MISR on SIGNATURE; otherwise SIGNATURE is tied to zero.
//
// Ports:
//   CLK, RST_N   clock (rising edge), synchronous active-low reset
//   START        begin a run (honoured only when idle)
//   ABORT        stop a run in progress
//   STIM         CUT inputs, STIM[k] drives Ik
//   RESP0/RESP1  CUT outputs O0/O1 (combinational w.r.t. STIM)
//   BUSY, DONE   run active / one-cycle completion pulse
//   PASS         result, valid from DONE until the next START
//   ERR_CNT      mismatching patterns, saturating
//   FAIL_VALID   a mismatch has been seen in this run
//   FIRST_FAIL   pattern index of the first mismatch
//   SIGNATURE    response signature (zero without the MISR)
module or_tree_pattern_checker #(
    parameter int unsigned NUM_IN     = 7,
    parameter int unsigned NOR_WIDTH  = 3,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned ERR_W      = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic                ABORT,
    output logic [NUM_IN-1:0]   STIM,
    input  logic                RESP0,
    input  logic                RESP1,
    output logic                BUSY,
    output logic                DONE,
    output logic                PASS,
    output logic [ERR_W-1:0]    ERR_CNT,
    output logic                FAIL_VALID,
    output logic [NUM_IN-1:0]   FIRST_FAIL,
    output logic [15:0]         SIGNATURE
);

    // One extra bit so the terminal pattern never wraps the counter.
    localparam int unsigned CNT_W = NUM_IN + 1;
    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'((1 << NUM_IN) - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [SET_W-1:0]   r_settle, w_settle;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_pass, w_pass;
    logic [ERR_W-1:0]   r_err, w_err;
    logic               r_fail_valid, w_fail_valid;
    logic [NUM_IN-1:0]  r_first_fail, w_first_fail;

    logic               w_exp0, w_exp1, w_mism;

`ifdef OR_TREE_CHECKER_MISR_EN
    localparam logic [15:0] MISR_POLY = 16'h100B;  // x^16+x^12+x^3+x+1
    logic [15:0]        r_sig, w_sig;
`endif

    // Golden response for the pattern currently on STIM.
    assign w_exp0 = |r_cnt[NUM_IN-1:0];
    assign w_exp1 = ~|r_cnt[NOR_WIDTH-1:0];
    assign w_mism = (RESP0 != w_exp0) || (RESP1 != w_exp1);

    // Next-state and datapath update.
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_settle     = r_settle;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_pass       = r_pass;
        w_err        = r_err;
        w_fail_valid = r_fail_valid;
        w_first_fail = r_first_fail;
`ifdef OR_TREE_CHECKER_MISR_EN
        w_sig        = r_sig;
`endif
        case (r_state)
            S_IDLE: begin
                if (START && !ABORT) begin
                    w_state      = S_SETTLE;
                    w_cnt        = '0;
                    w_settle     = '0;
                    w_busy       = 1'b1;
                    w_pass       = 1'b0;
                    w_err        = '0;
                    w_fail_valid = 1'b0;
                    w_first_fail = '0;
`ifdef OR_TREE_CHECKER_MISR_EN
                    w_sig        = '0;
`endif
                end
            end
            S_SETTLE: begin
                if (ABORT) begin
                    w_state  = S_IDLE;
                    w_cnt    = '0;
                    w_settle = '0;
                    w_busy   = 1'b0;
                    w_pass   = 1'b0;
                end else if (r_settle == SET_LAST) begin
                    w_state  = S_CHECK;
                    w_settle = '0;
                end else begin
                    w_settle = r_settle + SET_W'(1);
                end
            end
            S_CHECK: begin
                if (ABORT) begin
                    w_state  = S_IDLE;
                    w_cnt    = '0;
                    w_settle = '0;
                    w_busy   = 1'b0;
                    w_pass   = 1'b0;
                end else begin
                    if (w_mism) begin
                        if (r_err != '1) begin
                            w_err = r_err + ERR_W'(1);
                        end
                        if (!r_fail_valid) begin
                            w_fail_valid = 1'b1;
                            w_first_fail = r_cnt[NUM_IN-1:0];
                        end
                    end
`ifdef OR_TREE_CHECKER_MISR_EN
                    w_sig = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000)
                          ^ {14'h0000, RESP1, RESP0};
`endif
                    if (r_cnt == LAST_PAT) begin
                        // PASS is set with the DONE pulse so it already covers the last check.
                        w_state = S_DONE;
                        w_done  = 1'b1;
                        w_pass  = (w_err == '0);
                    end else begin
                        w_state = S_SETTLE;
                        w_cnt   = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_cnt   = '0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_settle     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_settle     <= w_settle;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_pass       <= w_pass;
            r_err        <= w_err;
            r_fail_valid <= w_fail_valid;
            r_first_fail <= w_first_fail;
        end
    end

`ifdef OR_TREE_CHECKER_MISR_EN
    // Response signature register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sig <= '0;
        end else begin
            r_sig <= w_sig;
        end
    end
    assign SIGNATURE = r_sig;
`else
    assign SIGNATURE = 16'h0000;
`endif

    assign STIM       = r_cnt[NUM_IN-1:0];
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign PASS       = r_pass;
    assign ERR_CNT    = r_err;
    assign FAIL_VALID = r_fail_valid;
    assign FIRST_FAIL = r_first_fail;

endmodule

// File: tb/tb_or_tree_pattern_checker.sv
// Bench for or_tree_pattern_checker: a fault-injectable CUT model drives two
// checker instances (ERR_W=8 and ERR_W=4); results are compared against a
// per-pattern reference computed from the golden OR/NOR rules.
module tb_or_tree_pattern_checker;

    localparam int NPAT = 128;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [6:0]  stim, stim4;
    logic        resp0, resp1, resp0_4, resp1_4;
    logic        busy, done, pass, fail_valid;
    logic [7:0]  err_cnt;
    logic [6:0]  first_fail;
    logic [15:0] signature;
    logic        busy4, done4, pass4, fail_valid4;
    logic [3:0]  err_cnt4;
    logic [6:0]  first_fail4;
    logic [15:0] signature4;

    // Fault controls for the CUT model.
    logic         stuck0, inv1;
    logic [127:0] inj0, inj1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // CUT: O0 = any input high, O1 = low three inputs all zero, plus faults.
    assign resp0   = stuck0 ? 1'b0 : ((stim != 7'd0) ^ inj0[stim]);
    assign resp1   = ((stim % 7'd8) == 7'd0) ^ inv1 ^ inj1[stim];
    assign resp0_4 = stuck0 ? 1'b0 : ((stim4 != 7'd0) ^ inj0[stim4]);
    assign resp1_4 = ((stim4 % 7'd8) == 7'd0) ^ inv1 ^ inj1[stim4];

    or_tree_pattern_checker u_dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort),
        .STIM(stim), .RESP0(resp0), .RESP1(resp1),
        .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt),
        .FAIL_VALID(fail_valid), .FIRST_FAIL(first_fail), .SIGNATURE(signature)
    );

    or_tree_pattern_checker #(.ERR_W(4)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort),
        .STIM(stim4), .RESP0(resp0_4), .RESP1(resp1_4),
        .BUSY(busy4), .DONE(done4), .PASS(pass4), .ERR_CNT(err_cnt4),
        .FAIL_VALID(fail_valid4), .FIRST_FAIL(first_fail4), .SIGNATURE(signature4)
    );

    // Count STIM steps seen while busy: +1 steps and anything else.
    int steps_ok = 0;
    int steps_bad = 0;
    logic [6:0] prev_stim = 7'd0;
    always @(negedge clk) begin
        if (busy && stim != prev_stim) begin
            if (stim == prev_stim + 7'd1) steps_ok++;
            else steps_bad++;
        end
        prev_stim = stim;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: mismatches over the first npat patterns given the fault controls.
    task automatic model(input int npat, output int err, output int first, output bit fv);
        bit e0, e1, r0, r1;
        err = 0; first = 0; fv = 0;
        for (int p = 0; p < npat; p++) begin
            e0 = (p > 0);
            e1 = ((p % 8) == 0);
            r0 = stuck0 ? 1'b0 : (e0 ^ inj0[p]);
            r1 = e1 ^ inv1 ^ inj1[p];
            if (r0 != e0 || r1 != e1) begin
                if (!fv) begin first = p; fv = 1; end
                err++;
            end
        end
    endtask

    // Run results
    int          lat, ndone, stim_at_done;
    logic [7:0]  pre_err;
    logic        post_busy, post_done, post_pass, post_fv;
    logic [7:0]  post_err;
    logic [6:0]  post_stim, post_ff;

    // Pulse START, optionally apply an event at cycle ev_cyc, watch for DONE.
    // ev_kind: 0 none, 1 START again, 2 ABORT, 3 RST_N low.
    task automatic do_run(input int ev_cyc, input int ev_kind, input int limit);
        lat = -1; ndone = 0; stim_at_done = -1;
        @(negedge clk); start = 1'b1;
        for (int n = 0; n <= limit; n++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; rst_n = 1'b1;
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = n; stim_at_done = int'(stim); end
            end
            if (n == ev_cyc) begin
                pre_err = err_cnt;
                case (ev_kind)
                    1: start = 1'b1;
                    2: abort = 1'b1;
                    3: rst_n = 1'b0;
                    default: ;
                endcase
            end
            if (n == ev_cyc + 1) begin
                post_busy = busy; post_done = done; post_pass = pass;
                post_fv = fail_valid; post_err = err_cnt;
                post_stim = stim; post_ff = first_fail;
            end
            if (lat >= 0 && n >= lat + 2) break;
        end
    endtask

    // Full-run checks against the reference.
    task automatic check_full(input string tag);
        int e, f; bit v;
        model(NPAT, e, f, v);
        chk({tag, "_latency"}, lat, 256);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_pass"}, pass, (e == 0) ? 1 : 0);
        chk({tag, "_err"}, err_cnt, (e > 255) ? 255 : e);
        chk({tag, "_fv"}, fail_valid, v);
        chk({tag, "_ff"}, first_fail, f);
        chk({tag, "_err4"}, err_cnt4, (e > 15) ? 15 : e);
        chk({tag, "_pass4"}, pass4, (e == 0) ? 1 : 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_stim_after"}, stim, 0);
    endtask

    initial begin
        int e, f, s0, sa, sb;
        bit v;
        logic [15:0] sig1, sig2, sig3;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        stuck0 = 1'b0; inv1 = 1'b0; inj0 = '0; inj1 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_fv", fail_valid, 0);
        chk("rst_ff", first_fail, 0);
        chk("rst_stim", stim, 0);
        chk("rst_sig", signature, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Golden run with stray START at cycle 100; STIM sweep tracked
        s0 = steps_ok; sb = steps_bad;
        do_run(100, 1, 400);
        check_full("golden");
        chk("golden_stim_at_done", stim_at_done, 127);
        chk("golden_steps", steps_ok - s0, 127);
        chk("golden_bad_steps", steps_bad - sb, 0);
        sig1 = signature;

        // Second golden run for signature repeatability
        do_run(-5, 0, 400);
        check_full("golden2");
        sig2 = signature;

        // RESP0 stuck-at-0
        stuck0 = 1'b1;
        do_run(-5, 0, 400);
        check_full("stuck0");

        // RESP1 inverted (ERR_W=4 instance saturates)
        stuck0 = 1'b0; inv1 = 1'b1;
        do_run(-5, 0, 400);
        check_full("inv1");

        // ABORT 50 cycles in, with stuck-at-0 so counters are nonzero
        inv1 = 1'b0; stuck0 = 1'b1;
        do_run(50, 2, 400);
        model(25, e, f, v);
        chk("abort_pre_err", pre_err, e);
        chk("abort_busy", post_busy, 0);
        chk("abort_stim", post_stim, 0);
        chk("abort_pass", post_pass, 0);
        chk("abort_err_kept", post_err, e);
        chk("abort_fv_kept", post_fv, v);
        chk("abort_ff_kept", post_ff, f);
        chk("abort_no_done", ndone, 0);

        // Reset low for one cycle at cycle 100
        do_run(100, 3, 400);
        model(50, e, f, v);
        chk("rstmid_pre_err", pre_err, e);
        chk("rstmid_busy", post_busy, 0);
        chk("rstmid_err", post_err, 0);
        chk("rstmid_fv", post_fv, 0);
        chk("rstmid_ff", post_ff, 0);
        chk("rstmid_stim", post_stim, 0);
        chk("rstmid_no_done", ndone, 0);
        stuck0 = 1'b0;
        do_run(-5, 0, 400);
        check_full("after_rst");

        // ABORT during the DONE cycle is ignored
        do_run(256, 2, 400);
        chk("abort_done_ndone", ndone, 1);
        chk("abort_done_pass", post_pass, 1);
        chk("abort_done_busy", post_busy, 0);

        // START and ABORT together in IDLE: stays idle
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("start_abort_busy_later", busy, 0);
        chk("start_abort_done", done, 0);

        // Single flipped RESP0 at pattern 77
        inj0[77] = 1'b1;
        do_run(-5, 0, 400);
        check_full("flip77");
        sig3 = signature;
        inj0 = '0;

        // Randomised sparse fault injection
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < NPAT; p++) begin
                inj0[p] = ($urandom_range(0, 15) == 0);
                inj1[p] = ($urandom_range(0, 15) == 0);
            end
            do_run(-5, 0, 400);
            check_full($sformatf("rand%0d", r));
        end
        inj0 = '0; inj1 = '0;

`ifdef OR_TREE_CHECKER_MISR_EN
        sa = int'(sig1); sb = int'(sig3);
        chk("sig_repeat", sig2, sa);
        chk("sig_nonzero", (sig1 != 16'h0) ? 1 : 0, 1);
        chk("sig_fault_differs", (sb != sa) ? 1 : 0, 1);
`else
        sa = int'(sig1) | int'(sig2) | int'(sig3);
        chk("sig_tied_zero", sa, 0);
        chk("sig4_tied_zero", signature4, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
